// File: rtl/girlword_sprite_fetch.sv
// rtl/girlword_sprite_fetch.sv - sliding 160x40 banner sprite fetch with 3-cycle pixel pipeline
// Optional blink in HOLD enabled by defining GIRLWORD_BLINK_EN.
module girlword_sprite_fetch #(
    parameter int BANNER_X    = 240,
    parameter int BANNER_Y    = 200,
    parameter int SHOW_FRAMES = 180
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        vsync,
    input  logic        show,
    output logic [12:0] rom_addr,
    input  logic [3:0]  rom_q,
    output logic [3:0]  index,
    output logic        pixel_on,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SLIDE, HOLD} state_t;

    localparam logic [9:0]  BX_LO     = 10'(BANNER_X);
    localparam logic [10:0] BX_HI     = 11'(BANNER_X + 159);
    localparam logic [9:0]  BY_FINAL  = 10'(BANNER_Y);
    localparam logic [15:0] HOLD_LAST = 16'(SHOW_FRAMES - 1);

    state_t      state_q;
    logic [6:0]  y_off_q;
    logic [15:0] hold_cnt_q;
    logic        vsync_q;
    logic        frame_tick;

    logic [12:0] rom_addr_q, rom_addr_d;
    logic        in_box1_q, vis1_q, in_box2_q, vis2_q;
    logic        pixel_on_q;
    logic [3:0]  index_q;

    logic [9:0]  top;
    logic [7:0]  dx;
    logic [5:0]  dy;
    logic        in_box;
    logic        visible;
    logic        opaque;

    assign frame_tick = vsync & ~vsync_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            y_off_q    <= 7'd0;
            hold_cnt_q <= 16'd0;
            vsync_q    <= 1'b0;
        end else begin
            vsync_q <= vsync;
            case (state_q)
                IDLE: begin
                    // show wins over a coincident frame_tick: start fully offset
                    if (show) begin
                        state_q <= SLIDE;
                        y_off_q <= 7'd64;
                    end
                end
                SLIDE: begin
                    if (frame_tick) begin
                        if (y_off_q <= 7'd4) begin
                            state_q    <= HOLD;
                            y_off_q    <= 7'd0;
                            hold_cnt_q <= 16'd0;
                        end else begin
                            y_off_q <= y_off_q - 7'd4;
                        end
                    end
                end
                HOLD: begin
                    if (show) begin
                        hold_cnt_q <= 16'd0;
                    end else if (frame_tick) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_q <= IDLE;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 16'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);

`ifdef GIRLWORD_BLINK_EN
    assign visible = (state_q == SLIDE) || ((state_q == HOLD) && !hold_cnt_q[4]);
`else
    assign visible = (state_q != IDLE);
`endif

    assign top    = BY_FINAL - {3'b000, y_off_q};
    assign in_box = (DrawX >= BX_LO) && ({1'b0, DrawX} <= BX_HI) &&
                    (DrawY >= top) && (DrawY <= top + 10'd39);
    assign dx     = 8'(DrawX - BX_LO);
    assign dy     = 6'(DrawY - top);

    always_comb begin
        rom_addr_d = 13'd0;
        if (in_box) begin
            rom_addr_d = 13'(dy) * 13'd160 + 13'(dx);
        end
    end

    assign opaque = in_box2_q & vis2_q & (rom_q != 4'd0);

    // Stage 1 issues the ROM read; stage 2 waits out its latency; stage 3 resolves transparency
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr_q <= 13'd0;
            in_box1_q  <= 1'b0;
            vis1_q     <= 1'b0;
            in_box2_q  <= 1'b0;
            vis2_q     <= 1'b0;
            pixel_on_q <= 1'b0;
            index_q    <= 4'd0;
        end else begin
            rom_addr_q <= rom_addr_d;
            in_box1_q  <= in_box;
            vis1_q     <= visible;
            in_box2_q  <= in_box1_q;
            vis2_q     <= vis1_q;
            pixel_on_q <= opaque;
            index_q    <= opaque ? rom_q : 4'd0;
        end
    end

    assign rom_addr = rom_addr_q;
    assign index    = index_q;
    assign pixel_on = pixel_on_q;

endmodule

// File: doc/girlword_sprite_fetch.md
GIRLWORD_SPRITE_FETCH -- requirements
Module: girlword_sprite_fetch

Interface
REQ-001 SHALL have parameter BANNER_X, default 240, meaning left column of the banner.
REQ-002 SHALL have parameter BANNER_Y, default 200, meaning final top row of the banner; legal range 64..439.
REQ-003 SHALL have parameter SHOW_FRAMES, default 180, meaning frames the banner is held after its slide completes.
REQ-004 SHALL have port Clk, input, 1, system pixel clock.
REQ-005 SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port DrawX, input, 10, current pixel column.
REQ-007 SHALL have port DrawY, input, 10, current pixel row.
REQ-008 SHALL have port vsync, input, 1, frame sync; synchronous to Clk.
REQ-009 SHALL have port show, input, 1, single-cycle request to display the banner.
REQ-010 SHALL have port rom_addr, output, 13, address to the external 160x40 index ROM (1-cycle read latency).
REQ-011 SHALL have port rom_q, input, 4, ROM data.
REQ-012 SHALL have port index, output, 4, palette index for the downstream palette stage.
REQ-013 SHALL have port pixel_on, output, 1, banner pixel is opaque and must override the background.
REQ-014 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 SHALL generate frame_tick for one cycle on each vsync rising edge (vsync high, registered vsync low).
REQ-016 SHALL implement states IDLE, SLIDE, HOLD; the banner is visible only in SLIDE and HOLD.
REQ-017 IDLE: show high -> SLIDE with y_off=64; show and frame_tick in the same cycle -> show wins, y_off not decremented.
REQ-018 SLIDE: each frame_tick decrements y_off by 4; when y_off would reach 0 -> HOLD with y_off=0 and hold_cnt=0; show ignored.
REQ-019 HOLD: each frame_tick increments hold_cnt; at hold_cnt==SHOW_FRAMES-1 with frame_tick -> IDLE; show in HOLD resets hold_cnt to 0.
REQ-020 Current top row SHALL be BANNER_Y - y_off; in_box = DrawX in [BANNER_X, BANNER_X+159] and DrawY in [top, top+39].
REQ-021 Pipeline stage 1 (cycle +1): register rom_addr = (DrawY-top)*160 + (DrawX-BANNER_X) when in_box, else 0; register in_box and visibility.
REQ-022 Pipeline stage 2 (cycle +2): delay in_box/visibility one further cycle to align with rom_q.
REQ-023 Pipeline stage 3 (cycle +3): register index = rom_q and pixel_on = in_box & visible & (rom_q != 0); when pixel_on is 0, index SHALL be 0.
REQ-024 Total latency DrawX/DrawY -> index/pixel_on SHALL be exactly 3 Clk cycles, constant, with no stalls.
REQ-025 Index 0 SHALL be treated as transparent.
REQ-026 State, y_off and hold_cnt SHALL change only on frame_tick or show, never mid-pixel otherwise.

Reset
REQ-027 Reset SHALL asynchronously force state=IDLE, y_off=0, hold_cnt=0, registered vsync=0, all pipeline registers 0.
REQ-028 During and directly after reset, rom_addr=0, index=0, pixel_on=0, busy=0.
REQ-029 Reset mid-SLIDE or mid-HOLD SHALL abort display; the next show restarts from y_off=64.

Configuration
REQ-030 Macro GIRLWORD_BLINK_EN defined: in HOLD, visible = ~hold_cnt[4], i.e. the banner toggles every 16 frames, starting visible.
REQ-031 GIRLWORD_BLINK_EN undefined: visible is constant 1 in HOLD; no blink logic is synthesized.

Verification
REQ-032 Reset asserted mid-frame -> index=0, pixel_on=0, busy=0, rom_addr=0 in the same cycle.
REQ-033 show in IDLE, then 16 frame_ticks -> busy=1, y_off 64,60,...,4, then HOLD with top=BANNER_Y.
REQ-034 In HOLD, DrawX=BANNER_X+3, DrawY=BANNER_Y+2 -> rom_addr=323 one cycle later; rom_q=5 -> index=5, pixel_on=1 at cycle +3; rom_q=0 -> pixel_on=0, index=0.
REQ-035 DrawX=BANNER_X+160 (just outside) -> pixel_on=0 regardless of rom_q.
REQ-036 show and frame_tick in the same cycle in IDLE -> SLIDE with y_off=64; show at HOLD hold_cnt=100 -> hold_cnt=0, IDLE reached SHOW_FRAMES ticks later.
REQ-037 With GIRLWORD_BLINK_EN, HOLD hold_cnt=16..31 -> pixel_on=0 for opaque ROM data; without it -> pixel_on=1.
